// File: rtl/scan_seq_pkg.sv
// Shared types and defaults for the scan sequencer: FSM state encoding and timing constants.
package scan_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int unsigned DEF_CHAIN_LEN = 8;
  localparam int unsigned DEF_DIV       = 4;
  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned PERIOD        = 2 * DEF_DIV;

  function automatic int unsigned period_of(input int unsigned div);
    return 2 * div;
  endfunction

endpackage

// File: rtl/scan_clk_gen.sv
// Scan clock divider: low for DIV cycles, then high for DIV cycles, while enabled.
// Flags the low->high transition (rise_edge_o) and the last cycle of each period (period_end_o).
module scan_clk_gen
  import scan_seq_pkg::*;
#(
  parameter int unsigned DIV   = DEF_DIV,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic scan_clk_o,
  output logic rise_edge_o,
  output logic period_end_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             phase_end;

  assign phase_end    = en_i && (cnt_q == LAST);
  assign rise_edge_o  = phase_end && !sclk_q;
  assign period_end_o = phase_end && sclk_q;
  assign scan_clk_o   = sclk_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      // Disabled means parked low, so every sequence starts with a low half-period.
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (phase_end) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Scan chain sequencer: start/busy/done handshake driving LOAD, SHIFT and CAPTURE phases.
// Optional gold comparison enabled by defining SCAN_SEQ_COMPARE_EN (adds gold_i).
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned DIV       = DEF_DIV,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_i,
  input  logic                 scan_out_i,
`ifdef SCAN_SEQ_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] gold_i,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 scan_clk_o,
  output logic                 scan_en_o,
  output logic                 load_gold_o,
  output logic                 scan_in_o,
  output logic [CHAIN_LEN-1:0] capture_o,
  output logic                 mismatch_o
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_e                 state_q, state_d;
  logic [CHAIN_LEN-1:0]   pat_q, pat_d;
  logic [CHAIN_LEN-1:0]   cap_q, cap_d;
  logic [CNT_W-1:0]       bit_q, bit_d;
  logic                   clk_en, rise_edge, period_end;

  assign clk_en = (state_q == LOAD) || (state_q == SHIFT) || (state_q == CAPTURE);

  scan_clk_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_clk_gen (
    .clk          (clk),
    .rst          (rst),
    .en_i         (clk_en),
    .scan_clk_o   (scan_clk_o),
    .rise_edge_o  (rise_edge),
    .period_end_o (period_end)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    cap_d       = cap_q;
    bit_d       = bit_q;
    busy        = clk_en;
    done        = 1'b0;
    scan_en_o   = 1'b0;
    load_gold_o = 1'b0;
    scan_in_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          pat_d   = pattern_i;
          cap_d   = '0;
          bit_d   = '0;
        end
      end
      LOAD: begin
        scan_en_o   = 1'b1;
        load_gold_o = 1'b1;
        if (period_end) state_d = SHIFT;
      end
      SHIFT: begin
        scan_en_o = 1'b1;
        scan_in_o = pat_q[0];
        if (rise_edge) cap_d = {scan_out_i, cap_q[CHAIN_LEN-1:1]};
        if (period_end) begin
          pat_d = pat_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = CAPTURE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (period_end) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cap_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cap_q   <= cap_d;
      bit_q   <= bit_d;
    end
  end

  assign capture_o = cap_q;

`ifdef SCAN_SEQ_COMPARE_EN
  logic mis_q, mis_d;

  // Result is taken once in DONE and held until the next accepted start.
  always_comb begin
    mis_d = mis_q;
    if (state_q == IDLE && start) mis_d = 1'b0;
    else if (state_q == DONE)     mis_d = |(cap_q ^ gold_i);
  end

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end

  assign mismatch_o = mis_q;
`else
  assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: default instance (8-bit chain, DIV=4) plus a
// minimal instance (2-bit chain, DIV=1) exercising back-to-back sequences.
module tb_scan_sequencer;

  localparam int CL     = 8;
  localparam int DV     = 4;
  localparam int CL_B   = 2;
  localparam int DV_B   = 1;
  localparam int BUSY_A = (CL + 2) * 2 * DV;
  localparam int BUSY_B = (CL_B + 2) * 2 * DV_B;
  localparam int WIN_A  = BUSY_A + 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  // ---------------- instance A (defaults) ----------------
  logic          start_a = 1'b0;
  logic [CL-1:0] pattern_a = '0;
  logic          sout_a;
  logic          busy_a, done_a, sclk_a, sen_a, lg_a, sin_a, mis_a;
  logic [CL-1:0] cap_a;

  // ---------------- instance B (CHAIN_LEN=2, DIV=1) ----------------
  logic            start_b = 1'b0;
  logic [CL_B-1:0] pattern_b = '0;
  logic            sout_b;
  logic            busy_b, done_b, sclk_b, sen_b, lg_b, sin_b, mis_b;
  logic [CL_B-1:0] cap_b;

`ifdef SCAN_SEQ_COMPARE_EN
  logic [CL-1:0]   gold_a = '0;
  logic [CL_B-1:0] gold_b = '0;
`endif

  scan_sequencer #(.CHAIN_LEN(CL), .DIV(DV), .CNT_W(8)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start_a),
    .pattern_i   (pattern_a),
    .scan_out_i  (sout_a),
`ifdef SCAN_SEQ_COMPARE_EN
    .gold_i      (gold_a),
`endif
    .busy        (busy_a),
    .done        (done_a),
    .scan_clk_o  (sclk_a),
    .scan_en_o   (sen_a),
    .load_gold_o (lg_a),
    .scan_in_o   (sin_a),
    .capture_o   (cap_a),
    .mismatch_o  (mis_a)
  );

  scan_sequencer #(.CHAIN_LEN(CL_B), .DIV(DV_B), .CNT_W(8)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .pattern_i   (pattern_b),
    .scan_out_i  (sout_b),
`ifdef SCAN_SEQ_COMPARE_EN
    .gold_i      (gold_b),
`endif
    .busy        (busy_b),
    .done        (done_b),
    .scan_clk_o  (sclk_b),
    .scan_en_o   (sen_b),
    .load_gold_o (lg_b),
    .scan_in_o   (sin_b),
    .capture_o   (cap_b),
    .mismatch_o  (mis_b)
  );

  // Behavioural scan chains: shift on a scan clock rise seen in shift mode (not gold load).
  logic [CL-1:0]   chain_a = '0, chain_ld_val_a = '0;
  logic            chain_ld_a = 1'b0, sclk_prev_a = 1'b0;
  logic [CL_B-1:0] chain_b = '0, chain_ld_val_b = '0;
  logic            chain_ld_b = 1'b0, sclk_prev_b = 1'b0;

  always @(posedge clk) begin
    sclk_prev_a <= sclk_a;
    if (chain_ld_a) chain_a <= chain_ld_val_a;
    else if (sclk_a && !sclk_prev_a && sen_a && !lg_a) chain_a <= {sin_a, chain_a[CL-1:1]};
    sclk_prev_b <= sclk_b;
    if (chain_ld_b) chain_b <= chain_ld_val_b;
    else if (sclk_b && !sclk_prev_b && sen_b && !lg_b) chain_b <= {sin_b, chain_b[CL_B-1:1]};
  end

  assign sout_a = chain_a[0];
  assign sout_b = chain_b[0];

  // Measurements of one run on instance A.
  int            m_busy, m_done, m_done_cyc, m_rise, m_lg, m_en, m_sin_n;
  logic [CL-1:0] m_sin, m_cap0;
  logic          m_mis0;

  task automatic load_chain_a(input logic [CL-1:0] v);
    chain_ld_a     = 1'b1;
    chain_ld_val_a = v;
    @(negedge clk);
    chain_ld_a = 1'b0;
  endtask

  // Called just after a negedge; pulses start, then observes WIN_A cycles.
  task automatic run_a(input logic [CL-1:0] pat, input int p1, input int p2);
    logic prev;
    m_busy = 0; m_done = 0; m_done_cyc = 0; m_rise = 0; m_lg = 0; m_en = 0;
    m_sin_n = 0; m_sin = '0; m_cap0 = '0; m_mis0 = 1'b0; prev = 1'b0;
    start_a   = 1'b1;
    pattern_a = pat;
    for (int i = 1; i <= WIN_A; i++) begin
      @(negedge clk);
      start_a = (i == p1) || (i == p2);
      if (i == 1) begin
        m_cap0 = cap_a;
        m_mis0 = mis_a;
      end
      if (busy_a) m_busy++;
      if (done_a) begin
        m_done++;
        if (m_done_cyc == 0) m_done_cyc = i;
      end
      if (lg_a) m_lg++;
      if (sen_a) m_en++;
      if (sclk_a && !prev) begin
        m_rise++;
        if (sen_a && !lg_a && m_sin_n < CL) begin
          m_sin[m_sin_n] = sin_a;
          m_sin_n++;
        end
      end
      prev = sclk_a;
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    logic [CL-1:0] v;
    int            dones;
    // State straight out of the initial reset.
    vec++;
    if ({busy_a, done_a, sclk_a, sen_a, lg_a, sin_a, mis_a, cap_a} !== '0) begin
      errs++;
      $display("FAIL reset_init_a: got %0h expected 0",
               {busy_a, done_a, sclk_a, sen_a, lg_a, sin_a, mis_a, cap_a});
    end
    vec++;
    if ({busy_b, done_b, sclk_b, sen_b, lg_b, sin_b, mis_b, cap_b} !== '0) begin
      errs++;
      $display("FAIL reset_init_b: got %0h expected 0",
               {busy_b, done_b, sclk_b, sen_b, lg_b, sin_b, mis_b, cap_b});
    end
    // Abort mid-SHIFT.
    load_chain_a(8'hFF);
    start_a   = 1'b1;
    pattern_a = 8'hFF;
    @(negedge clk);
    start_a = 1'b0;
    repeat (29) @(negedge clk);
    vec++;
    if (!(busy_a === 1'b1 && sen_a === 1'b1 && lg_a === 1'b0)) begin
      errs++;
      $display("FAIL reset_midshift_busy: got busy=%b en=%b lg=%b expected 1 1 0", busy_a, sen_a, lg_a);
    end
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if ({busy_a, done_a, sclk_a, sen_a, lg_a, sin_a, mis_a, cap_a} !== '0) begin
      errs++;
      $display("FAIL reset_abort_outputs: got %0h expected 0",
               {busy_a, done_a, sclk_a, sen_a, lg_a, sin_a, mis_a, cap_a});
    end
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < WIN_A; i++) begin
      @(negedge clk);
      if (done_a || busy_a) dones++;
    end
    vec++;
    if (dones != 0) begin
      errs++;
      $display("FAIL reset_no_done: got %0d busy/done cycles expected 0", dones);
    end
    v = CL'($urandom);
    load_chain_a(v);
    run_a(CL'($urandom), 0, 0);
    vec++;
    if (m_busy != BUSY_A || m_done_cyc != BUSY_A + 1) begin
      errs++;
      $display("FAIL reset_rerun: got busy=%0d done_at=%0d expected %0d %0d",
               m_busy, m_done_cyc, BUSY_A, BUSY_A + 1);
    end
    vec++;
    if (cap_a !== v) begin
      errs++;
      $display("FAIL reset_rerun_capture: got %0h expected %0h", cap_a, v);
    end
  endtask

  task automatic test_basic();
    logic [CL-1:0] pat;
    pat = 8'hA5;
    load_chain_a(8'h3C);
    run_a(pat, 0, 0);
    vec++;
    if (m_sin_n != CL || m_sin !== pat) begin
      errs++;
      $display("FAIL basic_scan_in: got %0h (%0d bits) expected %0h (%0d bits)", m_sin, m_sin_n, pat, CL);
    end
    vec++;
    if (cap_a !== 8'h3C) begin
      errs++;
      $display("FAIL basic_capture: got %0h expected 3c", cap_a);
    end
    vec++;
    if (m_done_cyc != BUSY_A + 1 || m_done != 1) begin
      errs++;
      $display("FAIL basic_done: got cycle %0d count %0d expected cycle %0d count 1",
               m_done_cyc, m_done, BUSY_A + 1);
    end
    vec++;
    if (m_busy != BUSY_A) begin
      errs++;
      $display("FAIL basic_busy: got %0d expected %0d", m_busy, BUSY_A);
    end
  endtask

  task automatic test_timing();
    load_chain_a(CL'($urandom));
    run_a(CL'($urandom), 0, 0);
    vec++;
    if (m_rise != CL + 2) begin
      errs++;
      $display("FAIL timing_rises: got %0d expected %0d", m_rise, CL + 2);
    end
    vec++;
    if (m_lg != 2 * DV) begin
      errs++;
      $display("FAIL timing_load_gold: got %0d expected %0d", m_lg, 2 * DV);
    end
    vec++;
    if (m_en != (CL + 1) * 2 * DV) begin
      errs++;
      $display("FAIL timing_scan_en: got %0d expected %0d", m_en, (CL + 1) * 2 * DV);
    end
  endtask

  task automatic test_start_ignored();
    logic [CL-1:0] v;
    v = CL'($urandom);
    load_chain_a(v);
    run_a(CL'($urandom), 10, 40);
    vec++;
    if (m_done != 1 || m_busy != BUSY_A) begin
      errs++;
      $display("FAIL start_ignored: got done=%0d busy=%0d expected 1 %0d", m_done, m_busy, BUSY_A);
    end
    vec++;
    if (cap_a !== v) begin
      errs++;
      $display("FAIL start_ignored_capture: got %0h expected %0h", cap_a, v);
    end
  endtask

  task automatic test_random();
    logic [CL-1:0] v, pat, prev_cap;
    for (int n = 0; n < 6; n++) begin
      prev_cap = cap_a;
      v   = CL'($urandom);
      pat = CL'($urandom);
      load_chain_a(v);
      run_a(pat, 0, 0);
      vec++;
      if (cap_a !== v || m_sin !== pat || m_done_cyc != BUSY_A + 1) begin
        errs++;
        $display("FAIL random_%0d: got cap=%0h sin=%0h done_at=%0d expected %0h %0h %0d",
                 n, cap_a, m_sin, m_done_cyc, v, pat, BUSY_A + 1);
      end
      vec++;
      if (m_cap0 !== '0) begin
        errs++;
        $display("FAIL random_clear_%0d: got %0h expected 0 (previous %0h)", n, m_cap0, prev_cap);
      end
    end
  endtask

  task automatic test_compare();
`ifdef SCAN_SEQ_COMPARE_EN
    gold_a = 8'h3C;
    load_chain_a(8'h3C);
    run_a(CL'($urandom), 0, 0);
    vec++;
    if (mis_a !== 1'b0) begin
      errs++;
      $display("FAIL compare_match: got %b expected 0", mis_a);
    end
    gold_a = 8'h3D;
    load_chain_a(8'h3C);
    run_a(CL'($urandom), 0, 0);
    vec++;
    if (mis_a !== 1'b1) begin
      errs++;
      $display("FAIL compare_miss: got %b expected 1", mis_a);
    end
    gold_a = 8'h00;
    load_chain_a(8'h00);
    run_a(CL'($urandom), 0, 0);
    vec++;
    if (m_mis0 !== 1'b0) begin
      errs++;
      $display("FAIL compare_clear: got %b expected 0", m_mis0);
    end
`else
    load_chain_a(CL'($urandom) | 8'h01);
    run_a(CL'($urandom), 0, 0);
    vec++;
    if (mis_a !== 1'b0) begin
      errs++;
      $display("FAIL compare_tied: got %b expected 0", mis_a);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [CL_B-1:0] v, pat;
    int              k;
    logic [2:0]      exp_v;
    v   = CL_B'($urandom);
    pat = CL_B'($urandom);
    chain_ld_b     = 1'b1;
    chain_ld_val_b = v;
    @(negedge clk);
    chain_ld_b = 1'b0;
    start_b   = 1'b1;
    pattern_b = pat;
    for (int i = 1; i <= 2 * (BUSY_B + 2); i++) begin
      @(negedge clk);
      if (i <= BUSY_B) k = i;
      else if (i >= BUSY_B + 3 && i <= 2 * BUSY_B + 2) k = i - (BUSY_B + 2);
      else k = 0;
      exp_v = {k != 0, (i == BUSY_B + 1) || (i == 2 * BUSY_B + 3), (k != 0) && ((k - 1) % 2 == 1)};
      vec++;
      if ({busy_b, done_b, sclk_b} !== exp_v) begin
        errs++;
        $display("FAIL b2b_cycle_%0d: got busy/done/sclk=%b expected %b", i, {busy_b, done_b, sclk_b}, exp_v);
      end
      // First sequence captures the preload; the second captures what the first shifted in.
      if (i == BUSY_B + 2) begin
        vec++;
        if (cap_b !== v) begin
          errs++;
          $display("FAIL b2b_capture_1: got %0h expected %0h", cap_b, v);
        end
      end
    end
    start_b = 1'b0;
    vec++;
    if (cap_b !== pat) begin
      errs++;
      $display("FAIL b2b_capture_2: got %0h expected %0h", cap_b, pat);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_timing();
    test_start_ignored();
    test_random();
    test_compare();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
